// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius sequence generator.
package genius_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  typedef logic [1:0] entry_t;

  // Right-shifting Fibonacci form: bits 0,2,3,5 realise x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS   = 16'h002D;
  localparam int          MAX_SEQ_LEN = 16;

  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/genius_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, loaded with seed under synchronous active-low reset.
module genius_lfsr16
  import genius_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {^(q_q & LFSR_TAPS), q_q[15:1]};
  end

  always_ff @(posedge clock) begin
    if (!reset) q_q <= seed;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/genius_seq_gen.sv
// Fills a SEQ_LEN-entry colour sequence from an LFSR on each start rising edge, then serves reads.
// Define GENIUS_SEQ_NO_REPEAT_EN to bump an entry that would repeat its predecessor.
//
// state | meaning
// IDLE  | no sequence stored since reset
// FILL  | writing one entry per cycle, wr_ptr 0..SEQ_LEN-1
// READY | sequence complete and readable
module genius_seq_gen
  import genius_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SEQ_LEN   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] index,
  output logic [1:0] current_number,
  output logic       ready
);

  localparam logic [15:0] SEED_EFF = fix_seed(LFSR_SEED);
  localparam logic [3:0]  LAST_PTR = 4'(SEQ_LEN - 1);

  state_t      state_q, state_d;
  logic        start_q;
  logic        start_edge;
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic        wr_en;
  entry_t      wr_data;
  entry_t      cur_q, cur_d;
  entry_t      mem_q [MAX_SEQ_LEN];
  logic [15:0] lfsr;
  logic        unused_lfsr;

  genius_lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (SEED_EFF),
    .q     (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:2];
  assign start_edge  = start & ~start_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d  = FILL;
          wr_ptr_d = 4'd0;
        end
      end
      FILL: begin
        wr_en = 1'b1;
        if (wr_ptr_q == LAST_PTR) begin
          state_d  = READY;
          wr_ptr_d = 4'd0;
        end else begin
          wr_ptr_d = wr_ptr_q + 4'd1;
        end
      end
      READY: begin
        if (start_edge) begin
          state_d  = FILL;
          wr_ptr_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_data = lfsr[1:0];
`ifdef GENIUS_SEQ_NO_REPEAT_EN
    if ((wr_ptr_q != 4'd0) && (lfsr[1:0] == mem_q[wr_ptr_q - 4'd1])) begin
      wr_data = lfsr[1:0] + 2'd1;
    end
`endif
  end

  // A start edge in READY blanks the read port in the same edge that drops ready.
  always_comb begin
    cur_d = 2'b00;
    if ((state_q == READY) && !start_edge && (int'(index) < SEQ_LEN)) begin
      cur_d = mem_q[index];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      start_q  <= 1'b1;
      wr_ptr_q <= 4'd0;
      cur_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      wr_ptr_q <= wr_ptr_d;
      cur_q    <= cur_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign current_number = cur_q;
  assign ready          = (state_q == READY);

endmodule

// File: tb/tb_genius_seq_gen.sv
// Self-checking bench: reset/control vector table, directed fill corner cases, randomized fills vs LFSR model.
module tb_genius_seq_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] index;
  logic [1:0] cur_a, cur_b;
  logic       rdy_a, rdy_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_a, m_b;

  always #5 clock = ~clock;

  genius_seq_gen #(.LFSR_SEED(16'hACE1), .SEQ_LEN(16)) dut_a (
    .clock(clock), .reset(reset), .start(start), .index(index),
    .current_number(cur_a), .ready(rdy_a)
  );

  genius_seq_gen #(.LFSR_SEED(16'h0000), .SEQ_LEN(5)) dut_b (
    .clock(clock), .reset(reset), .start(start), .index(index),
    .current_number(cur_b), .ready(rdy_b)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    int fb;
    fb = (int'(v[0]) + int'(v[2]) + int'(v[3]) + int'(v[5])) % 2;
    return 16'((int'(v) >> 1) + fb * 32768);
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_a <= 16'hACE1;
      m_b <= 16'h0001;
    end else begin
      m_a <= lfsr_next(m_a);
      m_b <= lfsr_next(m_b);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build(input logic [15:0] l0, input int len, output logic [1:0] e [16]);
    logic [15:0] l;
    logic [1:0]  cand;
    l = l0;
    for (int i = 0; i < 16; i++) e[i] = 2'b00;
    for (int i = 0; i < len; i++) begin
      cand = l[1:0];
`ifdef GENIUS_SEQ_NO_REPEAT_EN
      if (i > 0 && cand == e[i-1]) cand = cand + 2'd1;
`endif
      e[i] = cand;
      l = lfsr_next(l);
    end
  endtask

  // Called just after a falling edge; leaves start high.
  task automatic fill_check(input bit glitch, input int pre);
    logic [1:0] ea [16];
    logic [1:0] eb [16];
    int exp_b;
    start = 1'b0;
    repeat (pre) @(negedge clock);
    start = 1'b1;
    index = 4'($urandom);
    @(negedge clock);
    build(m_a, 16, ea);
    build(m_b, 5, eb);
    check("ready_a_k", int'(rdy_a), 0);
    check("ready_b_k", int'(rdy_b), 0);
    check("cur_a_k", int'(cur_a), 0);
    check("cur_b_k", int'(cur_b), 0);
    for (int j = 1; j <= 16; j++) begin
      if (glitch && j == 4) start = 1'b0;
      if (glitch && j == 5) start = 1'b1;
      index = 4'($urandom);
      exp_b = (j >= 6 && int'(index) < 5) ? int'(eb[index]) : 0;
      @(negedge clock);
      check("ready_a_fill", int'(rdy_a), (j >= 16) ? 1 : 0);
      check("ready_b_fill", int'(rdy_b), (j >= 5) ? 1 : 0);
      check("cur_a_fill", int'(cur_a), 0);
      check("cur_b_fill", int'(cur_b), exp_b);
    end
    for (int i = 0; i < 16; i++) begin
      index = 4'(i);
      @(negedge clock);
      check("entry_a", int'(cur_a), int'(ea[i]));
      check("entry_b", int'(cur_b), (i < 5) ? int'(eb[i]) : 0);
      check("ready_a_read", int'(rdy_a), 1);
`ifdef GENIUS_SEQ_NO_REPEAT_EN
      if (i > 0) check("adjacent_differ", (cur_a == ea[i-1]) ? 1 : 0, 0);
`endif
    end
  endtask

  typedef struct {
    logic       rst;
    logic       st;
    logic [3:0] idx;
    logic       exp_rdy;
    logic [1:0] exp_cur;
  } vec_t;

  vec_t tbl [9];

  initial begin
    reset = 1'b0;
    start = 1'b1;
    index = 4'd0;

    for (int i = 0; i < 3; i++) tbl[i] = '{1'b0, 1'b1, 4'd0, 1'b0, 2'd0};
    for (int i = 3; i < 7; i++) tbl[i] = '{1'b1, 1'b1, 4'd0, 1'b0, 2'd0};
    tbl[7] = '{1'b1, 1'b1, 4'd7, 1'b0, 2'd0};
    tbl[8] = '{1'b1, 1'b1, 4'd2, 1'b0, 2'd0};

    for (int i = 0; i < 9; i++) begin
      reset = tbl[i].rst;
      start = tbl[i].st;
      index = tbl[i].idx;
      @(negedge clock);
      check("tbl_ready_a", int'(rdy_a), int'(tbl[i].exp_rdy));
      check("tbl_ready_b", int'(rdy_b), int'(tbl[i].exp_rdy));
      check("tbl_cur_a", int'(cur_a), int'(tbl[i].exp_cur));
      check("tbl_cur_b", int'(cur_b), int'(tbl[i].exp_cur));
    end

    // First fill, then start held well past 50 cycles: no second fill.
    fill_check(1'b0, 1);
    repeat (34) begin
      @(negedge clock);
      check("hold_ready", int'(rdy_a), 1);
    end

    // Restart from READY with a start glitch 5 cycles into the fill.
    fill_check(1'b1, 2);

    // Reset during the eighth fill cycle.
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    repeat (8) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midfill_reset_ready", int'(rdy_a), 0);
    check("midfill_reset_cur", int'(cur_a), 0);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("post_reset_no_fill", int'(rdy_a), 0);
    end
    fill_check(1'b0, 1);

    for (int r = 0; r < 200; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      fill_check($urandom_range(0, 1) == 1, $urandom_range(1, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
